// File: rtl/q_ifid_fifo.sv
// q_ifid_fifo: instruction queue between fetch and decode.
// Each entry holds an instruction pair plus its PC values (PCA, CIA).
// Decode pops from the head in first-word-fall-through order; FLUSH clears
// the queue for branch redirects; overflow/underflow flags are sticky.
// Optional feature: define Q_IFID_ALMOST_FULL_EN to add the almost_full
// output (count >= AFULL_THRESH).
module q_ifid_fifo #(
  parameter int DEPTH        = 8,
  parameter int AW           = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  // fetch side
  input  logic        push_en,
  input  logic [31:0] push_instr1,
  input  logic [31:0] push_instr2,
  input  logic [31:0] push_pca,
  input  logic [31:0] push_cia,
  output logic        full,
  // decode side
  input  logic        pop_en,
  output logic [31:0] pop_instr1,
  output logic [31:0] pop_instr2,
  output logic [31:0] pop_pca,
  output logic [31:0] pop_cia,
  output logic        empty,
  // status
  output logic [AW:0] count,
  output logic        overflow_err,
  output logic        underflow_err
`ifdef Q_IFID_ALMOST_FULL_EN
  ,
  output logic        almost_full
`endif
);

  // One queue entry: the instruction pair and both PC values.
  typedef struct packed {
    logic [31:0] instr1;
    logic [31:0] instr2;
    logic [31:0] pca;
    logic [31:0] cia;
  } entry_t;

  localparam logic [AW:0] DepthC = (AW + 1)'(DEPTH);

  // Parameter sanity: the pointers wrap naturally only when DEPTH == 2**AW,
  // and the almost-full threshold must be a reachable occupancy.
  if (((1 << AW) != DEPTH) || (DEPTH < 2)) begin : g_bad_depth
    $error("q_ifid_fifo: DEPTH must be a power of two >= 2 equal to 2**AW");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_thresh
    $error("q_ifid_fifo: AFULL_THRESH must lie in 1..DEPTH");
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   rp_q, rp_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  // ---------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------
  logic   full_int;
  logic   empty_int;
  logic   pop_acc;
  logic   push_acc;
  entry_t push_entry;
  entry_t head_entry;

  assign full_int  = (count_q == DepthC);
  assign empty_int = (count_q == '0);

  // A pop is taken only when there is something to pop; a push is taken
  // when there is room, or when a same-cycle pop frees the slot. FLUSH
  // overrides both so a redirect never leaves stale or new entries behind.
  assign pop_acc  = pop_en && !empty_int && !FLUSH;
  assign push_acc = push_en && (!full_int || pop_acc) && !FLUSH;

  assign push_entry = '{instr1: push_instr1,
                        instr2: push_instr2,
                        pca:    push_pca,
                        cia:    push_cia};

  assign head_entry = mem_q[rp_q];

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    wp_d        = wp_q;
    rp_d        = rp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (FLUSH) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push_acc) begin
        wp_d = wp_q + AW'(1);
      end
      if (pop_acc) begin
        rp_d = rp_q + AW'(1);
      end
      // Simultaneous push and pop leave occupancy unchanged.
      if (push_acc && !pop_acc) begin
        count_d = count_q + (AW + 1)'(1);
      end else if (pop_acc && !push_acc) begin
        count_d = count_q - (AW + 1)'(1);
      end

      // Dropped push: queue full and no pop to make room.
      if (push_en && full_int && !pop_acc) begin
        overflow_d = 1'b1;
      end
      // Pop request against an empty queue.
      if (pop_en && empty_int) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Control registers; reset discards all entries immediately.
  always_ff @(posedge CLK or negedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of order.
    if (!RESET) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry storage: write the accepted push at the write pointer.
  always_ff @(posedge CLK) begin
    // NOTE: storage is deliberately not reset; count_q == 0 already marks
    // every slot invalid and the head outputs are forced to zero when empty.
    if (push_acc) begin
      mem_q[wp_q] <= push_entry;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------

  // Head entry falls through combinationally; zero while empty.
  always_comb begin
    pop_instr1 = '0;
    pop_instr2 = '0;
    pop_pca    = '0;
    pop_cia    = '0;
    if (!empty_int) begin
      pop_instr1 = head_entry.instr1;
      pop_instr2 = head_entry.instr2;
      pop_pca    = head_entry.pca;
      pop_cia    = head_entry.cia;
    end
  end

  assign full          = full_int;
  assign empty         = empty_int;
  assign count         = count_q;
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

`ifdef Q_IFID_ALMOST_FULL_EN
  localparam logic [AW:0] AfullC = (AW + 1)'(AFULL_THRESH);

  // Early warning so fetch can freeze before the queue actually fills.
  assign almost_full = (count_q >= AfullC);
`endif

endmodule

// File: tb/tb_q_ifid_fifo.sv
// Bench for q_ifid_fifo: a scoreboard queue mirrors accepted pushes and
// pops; each scenario task compares DUT outputs against it inline.
module tb_q_ifid_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        CLK;
  logic        RESET;
  logic        FLUSH;
  logic        push_en;
  logic [31:0] push_instr1, push_instr2, push_pca, push_cia;
  logic        full;
  logic        pop_en;
  logic [31:0] pop_instr1, pop_instr2, pop_pca, pop_cia;
  logic        empty;
  logic [AW:0] count;
  logic        overflow_err;
  logic        underflow_err;
`ifdef Q_IFID_ALMOST_FULL_EN
  logic        almost_full;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [127:0] sb[$];
  logic         ovf_m;
  logic         unf_m;

  q_ifid_fifo #(.DEPTH(DEPTH), .AW(AW), .AFULL_THRESH(6)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .FLUSH        (FLUSH),
    .push_en      (push_en),
    .push_instr1  (push_instr1),
    .push_instr2  (push_instr2),
    .push_pca     (push_pca),
    .push_cia     (push_cia),
    .full         (full),
    .pop_en       (pop_en),
    .pop_instr1   (pop_instr1),
    .pop_instr2   (pop_instr2),
    .pop_pca      (pop_pca),
    .pop_cia      (pop_cia),
    .empty        (empty),
    .count        (count),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
`ifdef Q_IFID_ALMOST_FULL_EN
    ,
    .almost_full  (almost_full)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Entry built from a seed; instr1 equals the seed.
  function automatic logic [127:0] mk(input logic [31:0] x);
    return {x, ~x, x + 32'h4, {x[29:0], 2'b00}};
  endfunction

  function automatic logic [127:0] exp_head();
    if (sb.size() != 0) return sb[0];
    return '0;
  endfunction

  function automatic logic [127:0] got_head();
    return {pop_instr1, pop_instr2, pop_pca, pop_cia};
  endfunction

  // Drive one cycle, update the scoreboard with what should be accepted.
  task automatic step(input logic p, input logic [31:0] x, input logic q,
                      input logic f);
    logic full_m, empty_m, pa, qa;
    full_m  = (sb.size() == DEPTH);
    empty_m = (sb.size() == 0);
    qa = q && !empty_m && !f;
    pa = p && (!full_m || qa) && !f;
    if (p && full_m && !qa && !f) ovf_m = 1'b1;
    if (q && empty_m && !f) unf_m = 1'b1;
    push_en = p;
    {push_instr1, push_instr2, push_pca, push_cia} = mk(x);
    pop_en = q;
    FLUSH  = f;
    @(posedge CLK);
    if (f) begin
      sb.delete();
    end else begin
      if (qa) sb.delete(0);
      if (pa) sb.push_back(mk(x));
    end
    #1;
    push_en = 1'b0;
    pop_en  = 1'b0;
    FLUSH   = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0; FLUSH = 1'b0; push_en = 1'b0; pop_en = 1'b0;
    push_instr1 = '0; push_instr2 = '0; push_pca = '0; push_cia = '0;
    ovf_m = 1'b0; unf_m = 1'b0;
    sb.delete();
    #12;
    tests_run++;
    if ({empty, full, count} !== {1'b1, 1'b0, 4'd0}) begin
      tests_failed++;
      $display("FAIL reset_flags got e=%b f=%b c=%0d exp e=1 f=0 c=0", empty, full, count);
    end
    tests_run++;
    if ({got_head(), overflow_err, underflow_err} !== 130'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got head=%h ovf=%b unf=%b exp all 0",
               got_head(), overflow_err, underflow_err);
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_fill_drain();
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) step(1'b1, vals[i], 1'b0, 1'b0);
    tests_run++;
    if ({count, empty, pop_instr1} !== {4'd3, 1'b0, 32'h11}) begin
      tests_failed++;
      $display("FAIL fill3 got c=%0d e=%b i1=%h exp c=3 e=0 i1=11", count, empty, pop_instr1);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (pop_instr1 !== vals[i] || got_head() !== exp_head()) begin
        tests_failed++;
        $display("FAIL drain_order[%0d] got %h exp %h", i, got_head(), exp_head());
      end
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    tests_run++;
    if ({empty, count, got_head()} !== {1'b1, 4'd0, 128'd0}) begin
      tests_failed++;
      $display("FAIL drained got e=%b c=%0d head=%h exp e=1 c=0 head=0", empty, count, got_head());
    end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h100 + i, 1'b0, 1'b0);
    tests_run++;
    if ({full, count, overflow_err} !== {1'b1, 4'd8, 1'b0}) begin
      tests_failed++;
      $display("FAIL full8 got f=%b c=%0d ovf=%b exp f=1 c=8 ovf=0", full, count, overflow_err);
    end
    step(1'b1, 32'h1FF, 1'b0, 1'b0);
    tests_run++;
    if ({overflow_err, count, full} !== {ovf_m, 4'd8, 1'b1}) begin
      tests_failed++;
      $display("FAIL overflow got ovf=%b c=%0d f=%b exp ovf=%b c=8 f=1",
               overflow_err, count, full, ovf_m);
    end
    tests_run++;
    if (pop_instr1 !== 32'h100 || got_head() !== exp_head()) begin
      tests_failed++;
      $display("FAIL overflow_head got %h exp %h", got_head(), exp_head());
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] last;
    last = '0;
    step(1'b1, 32'h99, 1'b1, 1'b0);
    tests_run++;
    if ({count, full, pop_instr1} !== {4'd8, 1'b1, 32'h101}) begin
      tests_failed++;
      $display("FAIL full_pushpop got c=%0d f=%b i1=%h exp c=8 f=1 i1=101", count, full, pop_instr1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tests_run++;
      if (got_head() !== exp_head()) begin
        tests_failed++;
        $display("FAIL full_drain[%0d] got %h exp %h", i, got_head(), exp_head());
      end
      last = pop_instr1;
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    tests_run++;
    if ({last, empty} !== {32'h99, 1'b1}) begin
      tests_failed++;
      $display("FAIL eighth_pop got i1=%h e=%b exp i1=99 e=1", last, empty);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h200 + i, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if (got_head() !== exp_head() || count !== 4'd4) begin
        tests_failed++;
        $display("FAIL wrap[%0d] got head=%h c=%0d exp head=%h c=4",
                 i, got_head(), count, exp_head());
      end
      step(1'b1, 32'h300 + i, 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got_head() !== exp_head() || pop_instr1 !== 32'h300 + 32'(16 + i)) begin
        tests_failed++;
        $display("FAIL wrap_drain[%0d] got %h exp %h", i, got_head(), exp_head());
      end
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    tests_run++;
    if (empty !== 1'b1 || underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_end got e=%b unf=%b exp e=1 unf=0", empty, underflow_err);
    end
  endtask

  task automatic test_flush_underflow();
    for (int i = 0; i < 5; i++) step(1'b1, 32'h400 + i, 1'b0, 1'b0);
    tests_run++;
    if (count !== 4'd5) begin
      tests_failed++;
      $display("FAIL pre_flush got c=%0d exp c=5", count);
    end
    step(1'b1, 32'h4FF, 1'b1, 1'b1);
    tests_run++;
    if ({count, empty, got_head(), underflow_err} !== {4'd0, 1'b1, 128'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL flush got c=%0d e=%b head=%h unf=%b exp c=0 e=1 head=0 unf=0",
               count, empty, got_head(), underflow_err);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if ({underflow_err, count, empty} !== {unf_m, 4'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL underflow got unf=%b c=%0d e=%b exp unf=%b c=0 e=1",
               underflow_err, count, empty, unf_m);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    tests_run++;
    if ({underflow_err, overflow_err} !== {1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL sticky got unf=%b ovf=%b exp unf=1 ovf=1", underflow_err, overflow_err);
    end
    step(1'b1, 32'h500, 1'b0, 1'b0);
    tests_run++;
    if ({count, got_head()} !== {4'd1, mk(32'h500)}) begin
      tests_failed++;
      $display("FAIL post_flush_push got c=%0d head=%h exp c=1 head=%h",
               count, got_head(), mk(32'h500));
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

`ifdef Q_IFID_ALMOST_FULL_EN
  task automatic test_almost_full();
    for (int i = 0; i < 5; i++) step(1'b1, 32'h600 + i, 1'b0, 1'b0);
    tests_run++;
    if (almost_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL afull_at5 got %b exp 0", almost_full);
    end
    step(1'b1, 32'h605, 1'b0, 1'b0);
    tests_run++;
    if (almost_full !== 1'b1) begin
      tests_failed++;
      $display("FAIL afull_at6 got %b exp 1", almost_full);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if (almost_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL afull_pop got %b exp 0", almost_full);
    end
    while (sb.size() != 0) step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask
`endif

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h700 + i, 1'b0, 1'b0);
    #2;
    RESET = 1'b0;
    sb.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    #1;
    tests_run++;
    if ({empty, full, count, overflow_err, underflow_err} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset got e=%b f=%b c=%0d ovf=%b unf=%b exp e=1 f=0 c=0 ovf=0 unf=0",
               empty, full, count, overflow_err, underflow_err);
    end
    tests_run++;
    if (got_head() !== 128'd0) begin
      tests_failed++;
      $display("FAIL async_reset_head got %h exp 0", got_head());
    end
`ifdef Q_IFID_ALMOST_FULL_EN
    tests_run++;
    if (almost_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_afull got %b exp 0", almost_full);
    end
`endif
    @(posedge CLK); #3;
    RESET = 1'b1;
    @(posedge CLK); #1;
    step(1'b1, 32'h777, 1'b0, 1'b0);
    tests_run++;
    if ({count, got_head()} !== {4'd1, exp_head()}) begin
      tests_failed++;
      $display("FAIL after_reset got c=%0d head=%h exp c=1 head=%h", count, got_head(), exp_head());
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_overflow();
    test_full_push_pop();
    test_wrap();
    test_flush_underflow();
`ifdef Q_IFID_ALMOST_FULL_EN
    test_almost_full();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
